// File: rtl/rs_decode_sequencer.sv
// Control sequencer for a Reed-Solomon decoder: steps the syndrome, Berlekamp-Massey,
// Chien search and Forney stages, with a per-stage watchdog and abort.
module rs_decode_sequencer #(
  parameter int unsigned MAX_ERRORS = 16,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned W = $clog2(2 * MAX_ERRORS),
  localparam int unsigned E = $clog2(MAX_ERRORS + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] cfg_nsym,
  output logic         syn_start,
  input  logic         syn_done,
  input  logic         syn_zero,
  output logic         bm_rst,
  output logic [W-1:0] bm_code_length,
  input  logic         bm_ready,
  input  logic [E-1:0] bm_degree,
  output logic         chien_start,
  input  logic         chien_done,
  input  logic [E-1:0] chien_roots,
  output logic         forney_start,
  input  logic         forney_done,
  output logic         busy,
  output logic         done,
  output logic [1:0]   status,
  output logic [E-1:0] err_count
);

  localparam int unsigned WdW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CmpW = ((W > E) ? W : E) + 1;
  // Last watchdog value on which an awaited done/ready is still accepted.
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StIdle, StSyn, StBmInit, StBmWait, StBmRun, StChien, StForney, StFinish
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   nsym_q, nsym_d;
  logic [E-1:0]   deg_q, deg_d;
  logic [E-1:0]   err_q, err_d;
  logic [1:0]     status_q, status_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           wd_expired, counting, deg_too_high;
  logic           syn_start_q, bm_rst_q, chien_start_q, forney_start_q, done_q, busy_q;

  assign wd_expired   = (wdog_q == WdLast);
  assign counting     = state_q inside {StSyn, StBmRun, StChien, StForney};
  assign deg_too_high = CmpW'(bm_degree) > CmpW'(nsym_q >> 1);

  always_comb begin
    state_d  = state_q;
    nsym_d   = nsym_q;
    deg_d    = deg_q;
    err_d    = err_q;
    status_d = status_q;
    wdog_d   = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          nsym_d   = cfg_nsym;
          status_d = 2'b00;
          err_d    = '0;
          state_d  = (cfg_nsym == '0) ? StFinish : StSyn;
        end
      end
      StSyn: begin
        if (syn_done) begin
          state_d = syn_zero ? StFinish : StBmInit;
        end else if (wd_expired) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end
      end
      StBmInit: state_d = StBmWait;
      StBmWait: state_d = StBmRun;
      StBmRun: begin
        if (bm_ready) begin
          deg_d = bm_degree;
          if (deg_too_high) begin
            state_d  = StFinish;
            status_d = 2'b10;
          end else begin
            state_d = StChien;
          end
        end else if (wd_expired) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end
      end
      StChien: begin
        if (chien_done) begin
          if (chien_roots != deg_q) begin
            state_d  = StFinish;
            status_d = 2'b10;
            err_d    = chien_roots;
          end else begin
            state_d = StForney;
          end
        end else if (wd_expired) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end
      end
      StForney: begin
        if (forney_done) begin
          state_d  = StFinish;
          status_d = 2'b01;
          err_d    = deg_q;
        end else if (wd_expired) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Abort overrides any stage completion seen in the same cycle.
    if (abort && !(state_q inside {StIdle, StFinish})) begin
      state_d  = StFinish;
      status_d = 2'b11;
      err_d    = '0;
    end

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (counting) begin
      wdog_d = wdog_q + WdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      nsym_q         <= '0;
      deg_q          <= '0;
      err_q          <= '0;
      status_q       <= 2'b00;
      wdog_q         <= '0;
      syn_start_q    <= 1'b0;
      bm_rst_q       <= 1'b0;
      chien_start_q  <= 1'b0;
      forney_start_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      nsym_q         <= nsym_d;
      deg_q          <= deg_d;
      err_q          <= err_d;
      status_q       <= status_d;
      wdog_q         <= wdog_d;
      syn_start_q    <= (state_d == StSyn) && (state_q != StSyn);
      bm_rst_q       <= (state_d == StBmInit);
      chien_start_q  <= (state_d == StChien) && (state_q != StChien);
      forney_start_q <= (state_d == StForney) && (state_q != StForney);
      done_q         <= (state_d == StFinish);
      busy_q         <= !(state_d inside {StIdle, StFinish});
    end
  end

  assign syn_start      = syn_start_q;
  assign bm_rst         = bm_rst_q;
  assign chien_start    = chien_start_q;
  assign forney_start   = forney_start_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign status         = status_q;
  assign err_count      = err_q;
  assign bm_code_length = nsym_q;

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Bench for rs_decode_sequencer: each decode is planned as a cycle timeline from stage
// delays, which drives the stage responses and predicts every output cycle.
module tb_rs_decode_sequencer;
  localparam int MAXE = 16;
  localparam int TO   = 16;
  localparam int LIM  = TO - 2;  // last in-stage cycle index on which a done is taken
  localparam int NC   = 128;
  localparam int W    = 5;
  localparam int E    = 5;
  localparam int B_BUSY = 5, B_DONE = 4, B_SYN = 3, B_RST = 2, B_CH = 1, B_FO = 0;

  logic clk = 1'b0;
  logic rst_n, start, abort, syn_done, syn_zero, bm_ready, chien_done, forney_done;
  logic [W-1:0] cfg_nsym, bm_code_length;
  logic [E-1:0] bm_degree, chien_roots, err_count;
  logic syn_start, bm_rst, chien_start, forney_start, busy, done;
  logic [1:0] status;

  always #5 clk = ~clk;

  rs_decode_sequencer #(.MAX_ERRORS(MAXE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_nsym(cfg_nsym),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero), .bm_rst(bm_rst),
    .bm_code_length(bm_code_length), .bm_ready(bm_ready), .bm_degree(bm_degree),
    .chien_start(chien_start), .chien_done(chien_done), .chien_roots(chien_roots),
    .forney_start(forney_start), .forney_done(forney_done), .busy(busy), .done(done),
    .status(status), .err_count(err_count)
  );

  typedef struct {
    logic start, abort, syn_done, syn_zero, bm_ready, chien_done, forney_done;
    logic [W-1:0] nsym;
    logic [E-1:0] deg, roots;
  } in_t;
  typedef struct {
    logic [5:0]   ctl;
    logic         chk_res, chk_len;
    logic [1:0]   status;
    logic [E-1:0] err;
    logic [W-1:0] len;
  } exp_t;
  typedef struct {
    int nsym, d_syn; bit zero; int d_bm, deg, d_ch, roots, d_fo, ab; bit stale; int stale_deg;
  } scen_t;

  in_t  tin[NC];
  exp_t texp[NC];
  int plan_len, fin, cyc;
  bit chk_en;
  int n_pass, n_chk;
  int done_at, done_cnt, syn_cnt, rst_cnt, ch_cnt, fo_cnt, syn_at, rst_at, ch_at, fo_at;
  int res_status, res_err;
  logic [5:0] ctl_now;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, want);
  endtask

  // Cycle on which a stage starting at cycle c is left, and why (0 done, 1 timeout, 2 abort).
  function automatic int stage_end(input int c, input int d, input int ab, output int how);
    int ev;
    ev  = c + ((d <= LIM) ? d : LIM);
    how = (d <= LIM) ? 0 : 1;
    if (ab >= c && ab <= ev) begin
      ev  = ab;
      how = 2;
    end
    return ev;
  endfunction

  task automatic plan(input scen_t s);
    int c, ev, how, st, er;
    for (int i = 0; i < NC; i++) begin
      tin[i].start       = 1'b0;
      tin[i].abort       = 1'b0;
      tin[i].nsym        = W'($urandom);
      tin[i].syn_done    = ($urandom_range(3) == 0);
      tin[i].syn_zero    = 1'($urandom);
      tin[i].bm_ready    = ($urandom_range(3) == 0);
      tin[i].chien_done  = ($urandom_range(3) == 0);
      tin[i].forney_done = ($urandom_range(3) == 0);
      tin[i].deg         = E'($urandom);
      tin[i].roots       = E'($urandom);
      texp[i] = '{ctl: '0, chk_res: 1'b0, chk_len: 1'b0, status: '0, err: '0, len: '0};
    end
    tin[0].start = 1'b1;
    tin[0].nsym  = W'(s.nsym);
    if (s.ab > 0) tin[s.ab].abort = 1'b1;
    c = 1; st = 3; er = 0;
    if (s.nsym == 0) begin
      fin = 1;
      st  = 0;
    end else begin
      texp[c].ctl[B_SYN] = 1'b1;
      for (int k = 0; k <= LIM; k++) tin[c+k].syn_done = (k == s.d_syn);
      if (s.d_syn <= LIM) tin[c+s.d_syn].syn_zero = s.zero;
      ev  = stage_end(c, s.d_syn, s.ab, how);
      fin = ev + 1;
      if (how == 0 && s.zero) st = 0;
      else if (how == 0) begin
        c = ev + 1;
        texp[c].ctl[B_RST] = 1'b1;
        if (s.stale) begin
          tin[c].bm_ready = 1'b1;
          tin[c+1].bm_ready = 1'b1;
          if (s.stale_deg >= 0) begin
            tin[c].deg   = E'(s.stale_deg);
            tin[c+1].deg = E'(s.stale_deg);
          end
        end
        if (s.ab == c || s.ab == c + 1) fin = s.ab + 1;
        else begin
          c = c + 2;
          for (int k = 0; k <= LIM; k++) tin[c+k].bm_ready = (k == s.d_bm);
          if (s.d_bm <= LIM) tin[c+s.d_bm].deg = E'(s.deg);
          ev  = stage_end(c, s.d_bm, s.ab, how);
          fin = ev + 1;
          if (how == 0 && s.deg > s.nsym / 2) st = 2;
          else if (how == 0) begin
            c = ev + 1;
            texp[c].ctl[B_CH] = 1'b1;
            for (int k = 0; k <= LIM; k++) tin[c+k].chien_done = (k == s.d_ch);
            if (s.d_ch <= LIM) tin[c+s.d_ch].roots = E'(s.roots);
            ev  = stage_end(c, s.d_ch, s.ab, how);
            fin = ev + 1;
            if (how == 0 && s.roots != s.deg) begin
              st = 2;
              er = s.roots;
            end else if (how == 0) begin
              c = ev + 1;
              texp[c].ctl[B_FO] = 1'b1;
              for (int k = 0; k <= LIM; k++) tin[c+k].forney_done = (k == s.d_fo);
              ev  = stage_end(c, s.d_fo, s.ab, how);
              fin = ev + 1;
              if (how == 0) begin
                st = 1;
                er = s.deg;
              end
            end
          end
        end
      end
    end
    for (int i = 1; i < fin; i++) begin
      texp[i].ctl[B_BUSY] = 1'b1;
      tin[i].start = ($urandom_range(3) == 0);
    end
    tin[fin].start = 1'($urandom_range(1));
    texp[fin].ctl[B_DONE] = 1'b1;
    plan_len = fin + 1 + $urandom_range(1, 3);
    for (int i = fin; i < plan_len; i++) begin
      texp[i].chk_res = 1'b1;
      texp[i].status  = 2'(st);
      texp[i].err     = E'(er);
      tin[i].abort    = 1'($urandom_range(1));
    end
    for (int i = 1; i < plan_len; i++) begin
      texp[i].chk_len = 1'b1;
      texp[i].len     = W'(s.nsym);
    end
  endtask

  task automatic drive(input int c);
    start = tin[c].start;       abort = tin[c].abort;       cfg_nsym = tin[c].nsym;
    syn_done = tin[c].syn_done; syn_zero = tin[c].syn_zero; bm_ready = tin[c].bm_ready;
    bm_degree = tin[c].deg;     chien_done = tin[c].chien_done;
    chien_roots = tin[c].roots; forney_done = tin[c].forney_done;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; cfg_nsym = '0; syn_done = 0; syn_zero = 0; bm_ready = 0;
    bm_degree = '0; chien_done = 0; chien_roots = '0; forney_done = 0;
  endtask

  task automatic run_plan(input int n);
    done_at = -1; done_cnt = 0; syn_cnt = 0; rst_cnt = 0; ch_cnt = 0; fo_cnt = 0;
    syn_at = -1; rst_at = -1; ch_at = -1; fo_at = -1; res_status = -1; res_err = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      cyc = c;
      drive(c);
      chk_en = 1'b1;
      @(negedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ctl_now = {busy, done, syn_start, bm_rst, chien_start, forney_start};
      check("ctl{busy,done,syn,bm_rst,chien,forney}", int'(ctl_now), int'(texp[cyc].ctl));
      if (texp[cyc].chk_res) begin
        check("status", int'(status), int'(texp[cyc].status));
        check("err_count", int'(err_count), int'(texp[cyc].err));
      end
      if (texp[cyc].chk_len) check("bm_code_length", int'(bm_code_length), int'(texp[cyc].len));
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        res_status = int'(status);
        res_err = int'(err_count);
      end
      if (syn_start) begin syn_cnt++; syn_at = cyc; end
      if (bm_rst) begin rst_cnt++; rst_at = cyc; end
      if (chien_start) begin ch_cnt++; ch_at = cyc; end
      if (forney_start) begin fo_cnt++; fo_at = cyc; end
    end
  end

  function automatic scen_t base();
    scen_t s;
    s = '{nsym: 8, d_syn: 0, zero: 1'b0, d_bm: 0, deg: 2, d_ch: 0, roots: 2, d_fo: 0,
          ab: -1, stale: 1'b0, stale_deg: -1};
    return s;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(9) == 0) ? int'($urandom_range(15, 19)) : int'($urandom_range(0, 8));
  endfunction

  initial begin
    scen_t s;
    int nd;
    n_pass = 0; n_chk = 0; chk_en = 1'b0; cyc = 0;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", int'({busy, done, syn_start, bm_rst, chien_start, forney_start}), 0);
    check("reset_status", int'(status), 0);
    check("reset_err", int'(err_count), 0);
    check("reset_len", int'(bm_code_length), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean word
    s = base(); s.d_syn = 5; s.zero = 1'b1;
    plan(s); run_plan(plan_len);
    check("clean_done_at", done_at, 7);
    check("clean_done_cnt", done_cnt, 1);
    check("clean_status", res_status, 0);
    check("clean_err", res_err, 0);
    check("clean_no_bm_rst", rst_cnt, 0);

    // Correctable word, pulse order pinned
    s = base(); s.d_syn = 2; s.d_bm = 3; s.deg = 3; s.d_ch = 4; s.roots = 3; s.d_fo = 2;
    plan(s); run_plan(plan_len);
    check("corr_syn_at", syn_at, 1);
    check("corr_bm_rst_at", rst_at, 4);
    check("corr_chien_at", ch_at, 10);
    check("corr_forney_at", fo_at, 15);
    check("corr_done_at", done_at, 18);
    check("corr_status", res_status, 1);
    check("corr_err", res_err, 3);

    // Degree too high
    s = base(); s.deg = 5; s.d_bm = 1;
    plan(s); run_plan(plan_len);
    check("deg_status", res_status, 2);
    check("deg_no_chien", ch_cnt, 0);

    // Root mismatch
    s = base(); s.deg = 2; s.roots = 1; s.d_ch = 3;
    plan(s); run_plan(plan_len);
    check("roots_status", res_status, 2);
    check("roots_err", res_err, 1);
    check("roots_no_forney", fo_cnt, 0);

    // Chien timeout
    s = base(); s.d_ch = 99;
    plan(s); run_plan(plan_len);
    check("to_chien_at", ch_at, 5);
    check("to_done_at", done_at, 20);
    check("to_status", res_status, 3);

    // Abort together with forney_done
    s = base(); s.deg = 1; s.roots = 1; s.d_fo = 2; s.ab = 8;
    plan(s); run_plan(plan_len);
    check("abort_done_at", done_at, 9);
    check("abort_status", res_status, 3);
    check("abort_err", res_err, 0);

    // Stale ready during BM_INIT/BM_WAIT with a degree that would be rejected
    s = base(); s.stale = 1'b1; s.stale_deg = 9; s.d_bm = 3; s.deg = 3; s.roots = 3;
    plan(s); run_plan(plan_len);
    check("stale_status", res_status, 1);
    check("stale_err", res_err, 3);

    // Trivial decode
    s = base(); s.nsym = 0;
    plan(s); run_plan(plan_len);
    check("nsym0_done_at", done_at, 1);
    check("nsym0_status", res_status, 0);
    check("nsym0_no_syn", syn_cnt, 0);

    repeat (300) begin
      s.nsym = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 31));
      s.d_syn = rand_delay();
      s.zero = ($urandom_range(3) == 0);
      s.d_bm = rand_delay();
      s.deg = int'($urandom_range(0, s.nsym / 2 + 2));
      s.d_ch = rand_delay();
      s.roots = ($urandom_range(3) == 0) ? int'($urandom_range(0, 16)) : s.deg;
      s.d_fo = rand_delay();
      s.ab = ($urandom_range(5) == 0) ? int'($urandom_range(1, 40)) : -1;
      s.stale = 1'($urandom_range(1));
      s.stale_deg = -1;
      plan(s); run_plan(plan_len);
      check("rand_done_cnt", done_cnt, 1);
    end

    // Reset in the middle of BM_RUN
    s = base(); s.d_bm = 99;
    plan(s); run_plan(7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_ctl", int'({done, syn_start, bm_rst, chien_start, forney_start}), 0);
    check("midrst_status", int'(status), 0);
    check("midrst_len", int'(bm_code_length), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    check("midrst_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
